// File: rtl/data_mem_pipe.sv
// data_mem_pipe
// Word-organised synchronous data memory with a valid/ready request channel
// and a valid/ready response channel. Loads are captured at acceptance and
// travel through RD_LAT response stages. Byte and half extension is applied
// at the output stage. Misaligned accesses, out-of-range accesses and
// undefined op codes are faulted: they never write memory, they return data 0
// with err 1, and they bump a saturating fault counter.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (accept on valid && ready)
//   req_we                1 = store, 0 = load
//   req_op                access type (DM_OP_* encodings below)
//   req_addr              byte address
//   req_wdata             store data, low lanes used for byte/half stores
//   resp_valid/resp_ready response handshake
//   resp_data             extended load data, 0 for stores and faults
//   resp_err              request faulted
//   addr_dbg, data_dbg    debug read port, one cycle latency, stall-independent
//   err_cnt               saturating count of faulted requests
module data_mem_pipe #(
  parameter  int ADDR_W    = 12,
  parameter  int RD_LAT    = 1,
  parameter  int CNT_W     = 16,
  localparam int DM_OP_BIT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [DM_OP_BIT-1:0] req_op,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  input  logic [31:0]          addr_dbg,
  output logic [31:0]          data_dbg,
  output logic [CNT_W-1:0]     err_cnt
);

  // Access type encodings shared with the core's MEM stage.
  localparam logic [DM_OP_BIT-1:0] DM_OP_WD = 3'b000;
  localparam logic [DM_OP_BIT-1:0] DM_OP_UH = 3'b001;
  localparam logic [DM_OP_BIT-1:0] DM_OP_UB = 3'b010;
  localparam logic [DM_OP_BIT-1:0] DM_OP_SH = 3'b011;
  localparam logic [DM_OP_BIT-1:0] DM_OP_SB = 3'b100;

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  typedef struct packed {
    logic                 valid;
    logic [DM_OP_BIT-1:0] op;
    logic [1:0]           lane;
    logic                 err;
    logic [31:0]          raw;
  } stage_t;

  logic [31:0]       mem_q [DEPTH];

  stage_t            st_q [RD_LAT];
  stage_t            st_d [RD_LAT];
  stage_t            last;

  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  err_cnt_d;
  logic [31:0]       data_dbg_q;
  logic [31:0]       data_dbg_d;

  logic              advance;
  logic              accept;
  logic              op_legal;
  logic              misalign;
  logic              out_of_range;
  logic              fault;
  logic              mem_we;
  logic [ADDR_W-3:0] wr_idx;
  logic [ADDR_W-3:0] dbg_idx;
  logic [31:0]       cur_word;
  logic [31:0]       wr_word;

  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       ext_data;

  logic              unused_dbg_bits;

  // Only the word index of the debug address matters.
  assign unused_dbg_bits = ^{addr_dbg[31:ADDR_W], addr_dbg[1:0]};

  // Handshake. The whole pipeline moves as one; a stalled output freezes
  // every stage, which keeps responses strictly in order.
  assign advance   = !st_q[RD_LAT-1].valid || resp_ready;
  assign req_ready = advance;
  assign accept    = req_valid && advance;

  assign wr_idx   = req_addr[ADDR_W-1:2];
  assign dbg_idx  = addr_dbg[ADDR_W-1:2];
  assign cur_word = mem_q[wr_idx];

  // Fault decode
  always_comb begin
    op_legal = 1'b0;
    misalign = 1'b0;
    case (req_op)
      DM_OP_WD: begin
        op_legal = 1'b1;
        misalign = (req_addr[1:0] != 2'b00);
      end
      DM_OP_UH, DM_OP_SH: begin
        op_legal = 1'b1;
        misalign = req_addr[0];
      end
      DM_OP_UB, DM_OP_SB: begin
        op_legal = 1'b1;
      end
      default: begin
        op_legal = 1'b0;
      end
    endcase
    out_of_range = |req_addr[31:ADDR_W];
    fault        = out_of_range || misalign || !op_legal;
  end

  // Store lane merge: only the addressed lane changes.
  always_comb begin
    wr_word = cur_word;
    case (req_op)
      DM_OP_UB, DM_OP_SB: wr_word[{req_addr[1:0], 3'b000} +: 8]  = req_wdata[7:0];
      DM_OP_UH, DM_OP_SH: wr_word[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
      default:            wr_word = req_wdata;
    endcase
  end

  // Requests seen while reset is asserted must not disturb memory contents.
  assign mem_we = accept && req_we && !fault && rst_n;

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx] <= wr_word;
    end
  end

  // Response pipeline next state. Load data is captured here, at acceptance,
  // so later stores cannot alter a load already in flight.
  always_comb begin
    for (int i = 0; i < RD_LAT; i++) begin
      st_d[i] = st_q[i];
    end
    if (advance) begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        st_d[i] = st_q[i-1];
      end
      st_d[0] = '0;
      if (accept) begin
        st_d[0].valid = 1'b1;
        st_d[0].op    = req_op;
        st_d[0].lane  = req_addr[1:0];
        st_d[0].err   = fault;
        // Stores and faults carry a zero word, which extends to zero.
        st_d[0].raw   = (!req_we && !fault) ? cur_word : 32'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        st_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RD_LAT; i++) begin
        st_q[i] <= st_d[i];
      end
    end
  end

  // Saturating fault counter
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && fault && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Debug read samples the pre-write word when a store hits the same edge.
  assign data_dbg_d = mem_q[dbg_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q  <= '0;
      data_dbg_q <= '0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      data_dbg_q <= data_dbg_d;
    end
  end

  // Output stage extension
  assign last = st_q[RD_LAT-1];

  always_comb begin
    case (last.lane)
      2'd0:    sel_byte = last.raw[7:0];
      2'd1:    sel_byte = last.raw[15:8];
      2'd2:    sel_byte = last.raw[23:16];
      default: sel_byte = last.raw[31:24];
    endcase
    sel_half = last.lane[1] ? last.raw[31:16] : last.raw[15:0];
    case (last.op)
      DM_OP_UB: ext_data = {24'h0, sel_byte};
      DM_OP_SB: ext_data = {{24{sel_byte[7]}}, sel_byte};
      DM_OP_UH: ext_data = {16'h0, sel_half};
      DM_OP_SH: ext_data = {{16{sel_half[15]}}, sel_half};
      default:  ext_data = last.raw;
    endcase
  end

  assign resp_valid = last.valid;
  assign resp_err   = last.valid && last.err;
  assign resp_data  = last.valid ? ext_data : 32'h0;
  assign data_dbg   = data_dbg_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_data_mem_pipe.sv
module tb_data_mem_pipe;

  localparam int ADDR_W = 12;
  localparam int RD_LAT = 3;
  localparam int CNT_W  = 2;

  localparam logic [2:0] OP_WD  = 3'b000;
  localparam logic [2:0] OP_UH  = 3'b001;
  localparam logic [2:0] OP_UB  = 3'b010;
  localparam logic [2:0] OP_SH  = 3'b011;
  localparam logic [2:0] OP_SB  = 3'b100;
  localparam logic [2:0] OP_BAD = 3'b111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_op;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic             resp_err;
  logic [31:0]      addr_dbg;
  logic [31:0]      data_dbg;
  logic [CNT_W-1:0] err_cnt;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_resp = 0;

  data_mem_pipe #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .addr_dbg(addr_dbg), .data_dbg(data_dbg), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: a response transfers at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      checks++;
      n_resp++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got data=%h err=%b required none", resp_data, resp_err);
      end else begin
        mon_e = sb.pop_front();
        if (resp_data !== mon_e.data || resp_err !== mon_e.err) begin
          errors++;
          $display("FAIL resp_order got data=%h err=%b required data=%h err=%b",
                   resp_data, resp_err, mon_e.data, mon_e.err);
        end
      end
    end
  end

  // Entered and left #1 after a rising edge.
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data,
                       input logic exp_err);
    int   w;
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout addr=%h req_ready=%b required 1", addr, req_ready);
    end else begin
      e.data = exp_data;
      e.err  = exp_err;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    resp_ready = 1'b1;
    while (sb.size() != 0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    int j;
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid  = 1'($urandom_range(0, 1));
      req_we     = 1'($urandom_range(0, 1));
      req_op     = 3'($urandom_range(0, 7));
      req_addr   = $urandom;
      req_wdata  = $urandom;
      resp_ready = 1'($urandom_range(0, 1));
      addr_dbg   = $urandom;
      @(negedge clk);
      checks += 6;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b required 0", resp_valid); end
      if (resp_data !== 32'h0) begin errors++; $display("FAIL rst_resp_data got %h required 0", resp_data); end
      if (resp_err !== 1'b0)   begin errors++; $display("FAIL rst_resp_err got %b required 0", resp_err); end
      if (data_dbg !== 32'h0)  begin errors++; $display("FAIL rst_data_dbg got %h required 0", data_dbg); end
      if (err_cnt !== '0)      begin errors++; $display("FAIL rst_err_cnt got %0d required 0", err_cnt); end
      if (req_ready !== 1'b1)  begin errors++; $display("FAIL rst_req_ready got %b required 1", req_ready); end
      @(posedge clk);
      #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    addr_dbg   = 32'h0;
    rst_n      = 1'b1;
    @(posedge clk);
    #1;
    // Store followed immediately by a load of the same word.
    issue(1'b1, OP_WD, 32'h10, 32'h11223344, 32'h0, 1'b0);
    issue(1'b0, OP_WD, 32'h10, 32'h0, 32'h11223344, 1'b0);
    wait_drain();
    // Isolated load: count cycles until the response appears.
    issue(1'b0, OP_WD, 32'h10, 32'h0, 32'h11223344, 1'b0);
    j = 0;
    @(negedge clk);
    while (!resp_valid && j < 10) begin
      j++;
      @(negedge clk);
    end
    checks++;
    if (j != RD_LAT - 1) begin
      errors++;
      $display("FAIL load_latency got %0d required %0d", j, RD_LAT - 1);
    end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  task automatic test_lanes();
    issue(1'b1, OP_WD, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b0);
    issue(1'b1, OP_SB, 32'h21, 32'h00000080, 32'h0, 1'b0);
    issue(1'b1, OP_SH, 32'h22, 32'h0000A5A5, 32'h0, 1'b0);
    issue(1'b0, OP_WD, 32'h20, 32'h0, 32'hA5A580FF, 1'b0);
    issue(1'b0, OP_SB, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0);
    issue(1'b0, OP_UB, 32'h21, 32'h0, 32'h00000080, 1'b0);
    issue(1'b0, OP_SH, 32'h22, 32'h0, 32'hFFFFA5A5, 1'b0);
    issue(1'b0, OP_UH, 32'h22, 32'h0, 32'h0000A5A5, 1'b0);
    issue(1'b0, OP_UH, 32'h20, 32'h0, 32'h000080FF, 1'b0);
    issue(1'b0, OP_SH, 32'h20, 32'h0, 32'hFFFF80FF, 1'b0);
    issue(1'b0, OP_SB, 32'h20, 32'h0, 32'hFFFFFFFF, 1'b0);
    issue(1'b0, OP_UB, 32'h23, 32'h0, 32'h000000A5, 1'b0);
    wait_drain();
  endtask

  task automatic test_faults();
    logic [2:0]  f_op   [4] = '{OP_SH, OP_WD, OP_WD, OP_BAD};
    logic        f_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] f_addr [4] = '{32'h21, 32'h22, 32'h1000, 32'h20};
    int          exp_cnt;
    for (int i = 0; i < 4; i++) begin
      issue(f_we[i], f_op[i], f_addr[i], 32'h12345678, 32'h0, 1'b1);
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      checks++;
      if (err_cnt !== CNT_W'(exp_cnt)) begin
        errors++;
        $display("FAIL fault_cnt_%0d got %0d required %0d", i, err_cnt, exp_cnt);
      end
    end
    // Misaligned store targeted word 0x20: it must be untouched.
    issue(1'b0, OP_WD, 32'h20, 32'h0, 32'hA5A580FF, 1'b0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev_data;
    logic        prev_err;
    logic        prev_stall;
    int          stalls;
    int          base_resp;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, OP_WD, 32'h40 + 32'(4 * i), 32'hB0B00000 + 32'(i * 17), 32'h0, 1'b0);
    end
    wait_drain();
    base_resp  = n_resp;
    prev_stall = 1'b0;
    prev_data  = 32'h0;
    prev_err   = 1'b0;
    stalls     = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          issue(1'b0, OP_WD, 32'h40 + 32'(4 * i), 32'h0, 32'hB0B00000 + 32'(i * 17), 1'b0);
        end
      end
      begin
        for (int c = 0; c < 24; c++) begin
          resp_ready = (c % 3 == 0);
          @(posedge clk);
          #1;
        end
        resp_ready = 1'b1;
      end
      begin
        for (int c = 0; c < 24; c++) begin
          @(negedge clk);
          checks++;
          if (req_ready !== (!resp_valid || resp_ready)) begin
            errors++;
            $display("FAIL bp_req_ready got %b required %b", req_ready, !resp_valid || resp_ready);
          end
          if (prev_stall) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== prev_data || resp_err !== prev_err) begin
              errors++;
              $display("FAIL bp_hold got v=%b d=%h e=%b required v=1 d=%h e=%b",
                       resp_valid, resp_data, resp_err, prev_data, prev_err);
            end
          end
          prev_stall = resp_valid && !resp_ready;
          if (prev_stall) stalls++;
          prev_data = resp_data;
          prev_err  = resp_err;
        end
      end
    join
    wait_drain();
    checks += 2;
    if (n_resp - base_resp != 5) begin
      errors++;
      $display("FAIL bp_resp_count got %0d required 5", n_resp - base_resp);
    end
    if (stalls == 0) begin
      errors++;
      $display("FAIL bp_stall_seen got 0 required >0");
    end
  endtask

  task automatic test_debug();
    addr_dbg = 32'h20;
    @(posedge clk);
    #1;
    checks++;
    if (data_dbg !== 32'hA5A580FF) begin errors++; $display("FAIL dbg_read got %h required a5a580ff", data_dbg); end
    addr_dbg = 32'hFFFFF010;
    @(posedge clk);
    #1;
    checks++;
    if (data_dbg !== 32'h11223344) begin errors++; $display("FAIL dbg_upper_ignored got %h required 11223344", data_dbg); end
    issue(1'b1, OP_WD, 32'h10, 32'hCAFEBABE, 32'h0, 1'b0);
    checks++;
    if (data_dbg !== 32'h11223344) begin errors++; $display("FAIL dbg_same_edge got %h required 11223344", data_dbg); end
    @(posedge clk);
    #1;
    checks++;
    if (data_dbg !== 32'hCAFEBABE) begin errors++; $display("FAIL dbg_next_edge got %h required cafebabe", data_dbg); end
    issue(1'b0, OP_WD, 32'h10, 32'h0, 32'hCAFEBABE, 1'b0);
    wait_drain();
  endtask

  task automatic test_reset_midflight();
    issue(1'b1, OP_WD, 32'h60, 32'h5A5A5A5A, 32'h0, 1'b0);
    wait_drain();
    issue(1'b0, OP_WD, 32'h60, 32'h0, 32'h5A5A5A5A, 1'b0);
    issue(1'b0, OP_WD, 32'h40, 32'h0, 32'hB0B00000, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b required 0", resp_valid); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_dropped got %b required 0", resp_valid); end
    end
    @(posedge clk);
    #1;
    checks++;
    if (err_cnt !== '0) begin errors++; $display("FAIL mid_rst_cnt got %0d required 0", err_cnt); end
    issue(1'b0, OP_WD, 32'h60, 32'h0, 32'h5A5A5A5A, 1'b0);
    issue(1'b0, OP_WD, 32'h10, 32'h0, 32'hCAFEBABE, 1'b0);
    wait_drain();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, OP_UH, 32'h23, 32'h0, 32'h0, 1'b1);
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      checks++;
      if (err_cnt !== CNT_W'(exp_cnt)) begin
        errors++;
        $display("FAIL sat_cnt_%0d got %0d required %0d", i, err_cnt, exp_cnt);
      end
    end
    wait_drain();
  endtask

  initial begin
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_op     = OP_WD;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;
    addr_dbg   = 32'h0;
    rst_n      = 1'b0;
    test_reset();
    test_lanes();
    test_faults();
    test_back_to_back();
    test_debug();
    test_reset_midflight();
    test_saturation();
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_pipe.md
# data_mem_pipe

Parametrised successor to the core's data memory. It is a word-organised synchronous RAM with a valid/ready request channel and a valid/ready response channel, a configurable read pipeline depth, and byte/half/word access using the `DM_OP_*` encodings from `Core.vh`. It also provides misalignment and range fault reporting, a registered debug read port, and a saturating fault counter. It sits between the MEM stage and storage, replacing the combinational-read memory.

## Interface
- `ADDR_W`, default 12: byte-address bits decoded. Depth is 2^(ADDR_W-2) words; legal range is 3..16.
- `RD_LAT`, default 1: response pipeline stages; legal range is 1..3.
- `CNT_W`, default 16: width of `err_cnt`.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_we` in 1: 1 = store, 0 = load.
- `req_op` in `DM_OP_BIT`: access type, one of `DM_OP_WD`, `DM_OP_UH`, `DM_OP_UB`, `DM_OP_SH`, `DM_OP_SB`.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, taken from the low lanes (bits [7:0] for bytes, [15:0] for halves).
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_data` out 32: load result (extended); 0 for stores and faults.
- `resp_err` out 1: the request faulted.
- `addr_dbg` in 32: debug byte address.
- `data_dbg` out 32: word at `addr_dbg[ADDR_W-1:2]`, registered.
- `err_cnt` out `CNT_W`: count of faulted requests, saturating.

## Operation
- **Pipeline.** `RD_LAT` stages s1..sL, each holding valid, op, addr[1:0], err, and raw word.
  - advance = !resp_valid || resp_ready
  - req_ready = advance
  - When advance=0, every stage holds its contents.
- **Fault.** fault = (`req_addr[31:ADDR_W]` != 0) || (op ∈ {UH,SH} && addr[0]) || (op == WD && addr[1:0] != 0) || op not a defined code.
- **Store (accepted, no fault).**
  - The lane write commits at the accept edge.
  - SB/UB writes byte lane addr[1:0]; SH/UH writes half lane addr[1]; WD writes the full word.
  - Other lanes are unchanged.
  - A response is still produced: data 0, err 0.
- **Load (accepted, no fault).** The whole word is read at the accept edge into s1. Extension is applied at the output:
  - UB/UH: zero-extend.
  - SB/SH: sign-extend from bit 7/15 of the selected lane.
  - WD: the word as-is.
- **Faulted request.** No memory write. Response has data 0, err 1. `err_cnt` increments at the accept edge and saturates at all-ones.
- **Ordering.** Responses return strictly in request order, exactly one per accepted request. A load accepted after a store to the same word returns the stored value. Load data is frozen at acceptance, so later stores never alter a load already in flight.
- **Debug port.** `data_dbg` <= mem[`addr_dbg[ADDR_W-1:2]`] every cycle, independent of stalls. Upper address bits are ignored. If a store commits to the same word at the same edge, `data_dbg` shows the old value.
- **Reset.**
  - Pipeline valids cleared.
  - `resp_valid`=0, `resp_data`=0, `resp_err`=0, `data_dbg`=0, `err_cnt`=0.
  - `req_ready`=1 while `rst_n`=0.
  - Memory contents are not reset.
  - Reset mid-operation drops in-flight responses; stores already committed persist.

## Timing
- Accepted at edge k means the response is visible on the outputs from edge k+RD_LAT-1 onward:
  - RD_LAT=1: visible in the cycle immediately following acceptance.
  - RD_LAT=3: visible two cycles after that.
- Throughput is 1 request/cycle when `resp_ready`=1.
- **Back-pressure.** `resp_valid`=1 with `resp_ready`=0 drops `req_ready` combinationally. Outputs must hold stable until accepted.
- Response transfer and a new request acceptance may occur at the same edge.
- Store-to-load to the same word is back-to-back: store at edge k, load at edge k+1 sees the new data.
- `data_dbg` latency is 1 cycle from `addr_dbg`.

## Test plan
- **Reset.** Hold `rst_n`=0 with random inputs → all outputs 0, `req_ready`=1. Release, then SW 0x11223344 @0x10 followed by LW @0x10 → load response 0x11223344, err 0.
- **Lane stores.** SW 0xFFFFFFFF @0x20, SB 0x80 @0x21, SH 0xA5A5 @0x22, then:
  - LW → 0xA5A580FF
  - LB @0x21 → 0xFFFFFF80
  - LBU @0x21 → 0x00000080
  - LH @0x22 → 0xFFFFA5A5
- **Faults.** Each request must return err=1 with data 0, leave memory unchanged, and `err_cnt` must reach 3:
  - LH @0x21 (odd half)
  - SW @0x22 (misaligned word)
  - LW @0x1000 with ADDR_W=12 (out of range)
- **Back-pressure, RD_LAT=3.** Issue 5 back-to-back loads with `resp_ready` toggled 1,0,0,1,… → `req_ready` mirrors stalls, 5 responses arrive in order with no duplicates, and outputs are stable during the stall.
- **Reset and saturation.**
  - Assert `rst_n` with 2 loads in flight → no responses after release; memory retains prior stores.
  - With CNT_W=2, issue 5 faults → `err_cnt`=3.
- **Debug port.** Set `addr_dbg`=0x10 while an SW to 0x10 commits at edge k → `data_dbg` is old at k, new at k+1.
